// File: rtl/lc3b_types.sv
// Shared types and the tree pseudo-LRU update rule for the 4-way victim tracker.
// Contents: lc3b_lru_state (3-bit tree state), lc3b_way (2-bit way number),
// and lru_update(), the single definition of how an access moves the tree.
package lc3b_types;

  localparam int unsigned LRU_W    = 3;
  localparam int unsigned WAY_W    = 2;
  localparam int unsigned NUM_WAYS = 4;

  typedef logic [LRU_W-1:0] lc3b_lru_state;
  typedef logic [WAY_W-1:0] lc3b_way;

  // bit0: MRU half (1 = ways 2/3); bit1: MRU within 0/1; bit2: MRU within 2/3.
  function automatic lc3b_lru_state lru_update(input lc3b_lru_state cur,
                                               input lc3b_way       way);
    lc3b_lru_state nxt;
    nxt    = cur;
    nxt[0] = way[1];
    if (way[1]) nxt[2] = way[0];
    else        nxt[1] = way[0];
    return nxt;
  endfunction

endpackage

// File: rtl/lru_victim_array_select.sv
// Combinational victim decode for one set.
// Ports: lru_state - tree pseudo-LRU bits of the set
//        way_valid - valid bits of the set's four ways
//        victim_c  - way to replace (lowest invalid way wins over the tree)
module lru_victim_select
  import lc3b_types::*;
(
  input  lc3b_lru_state         lru_state,
  input  logic [NUM_WAYS-1:0]   way_valid,
  output lc3b_way               victim_c
);

  lc3b_way tree_victim;

  // Walk away from the MRU half, then away from the MRU way inside it.
  always_comb begin
    tree_victim = '0;
    if (lru_state[0]) tree_victim = {1'b0, ~lru_state[1]};
    else              tree_victim = {1'b1, ~lru_state[2]};
  end

  // Filling an empty way always beats evicting a live one.
  always_comb begin
    victim_c = tree_victim;
    if      (!way_valid[0]) victim_c = WAY_W'(0);
    else if (!way_valid[1]) victim_c = WAY_W'(1);
    else if (!way_valid[2]) victim_c = WAY_W'(2);
    else if (!way_valid[3]) victim_c = WAY_W'(3);
  end

endmodule

// File: rtl/lru_victim_array.sv
// Per-set tree pseudo-LRU state array with a registered victim lookup.
// Ports: clk, rst (async active-high)
//        access_valid/access_index/access_way - hit or fill, updates one set
//        query_valid/query_index/way_valid    - victim lookup request
//        victim_way   - registered victim, holds between queries
//        victim_valid - one-cycle pulse, victim_way is new
// Build option: LRU_BYPASS_EN - a same-cycle access to the queried set is
// forwarded so the victim reflects the post-update state.
module lru_victim_array
  import lc3b_types::*;
#(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned IDX_W    = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                access_valid,
  input  logic [IDX_W-1:0]    access_index,
  input  lc3b_way             access_way,
  input  logic                query_valid,
  input  logic [IDX_W-1:0]    query_index,
  input  logic [NUM_WAYS-1:0] way_valid,
  output lc3b_way             victim_way,
  output logic                victim_valid
);

  lc3b_lru_state state_q [NUM_SETS];
  lc3b_lru_state query_state_c;
  lc3b_way       victim_c;

  // LRU state array; only accesses move it, queries are read-only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SETS; i++) state_q[i] <= '0;
    end else if (access_valid) begin
      state_q[access_index] <= lru_update(state_q[access_index], access_way);
    end
  end

  // State seen by the query: stored value, or forwarded same-set update.
  always_comb begin
    query_state_c = state_q[query_index];
`ifdef LRU_BYPASS_EN
    if (access_valid && (access_index == query_index))
      query_state_c = lru_update(state_q[query_index], access_way);
`endif
  end

  lru_victim_select u_select (
    .lru_state (query_state_c),
    .way_valid (way_valid),
    .victim_c  (victim_c)
  );

  // Registered result: pulse on each query, way holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      victim_way   <= '0;
      victim_valid <= 1'b0;
    end else begin
      victim_valid <= query_valid;
      if (query_valid) victim_way <= victim_c;
    end
  end

endmodule

// File: tb/tb_lru_victim_array.sv
// Self-checking bench for lru_victim_array: a per-set "which half / which way
// was used last" model predicts every output cycle, plus hand-computed
// literal expectations for the directed scenarios.
module tb_lru_victim_array;

  localparam int unsigned NUM_SETS = 8;
  localparam int unsigned IDX_W    = 3;

  logic             clk;
  logic             rst;
  logic             access_valid;
  logic [IDX_W-1:0] access_index;
  logic [1:0]       access_way;
  logic             query_valid;
  logic [IDX_W-1:0] query_index;
  logic [3:0]       way_valid;
  logic [1:0]       victim_way;
  logic             victim_valid;

  int n_checks;
  int n_fail;
  bit checking;

  lru_victim_array #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .access_valid (access_valid),
    .access_index (access_index),
    .access_way   (access_way),
    .query_valid  (query_valid),
    .query_index  (query_index),
    .way_valid    (way_valid),
    .victim_way   (victim_way),
    .victim_valid (victim_valid)
  );

  always #5 clk = ~clk;

  // Model: for each set, which half was used last and which way in each half.
  int   last_half [NUM_SETS];
  int   last_in_half [NUM_SETS][2];
  logic [1:0] exp_way;
  logic       exp_valid;

  function automatic int model_victim(input int half_used, input int lo_used,
                                      input int hi_used, input logic [3:0] wv);
    int half;
    int used;
    for (int i = 0; i < 4; i++) if (wv[i] == 1'b0) return i;
    half = 1 - half_used;
    used = (half == 0) ? lo_used : hi_used;
    return half * 2 + (1 - used);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        last_half[s] = 0;
        last_in_half[s][0] = 0;
        last_in_half[s][1] = 0;
      end
      exp_way   = 2'd0;
      exp_valid = 1'b0;
    end else begin
      int qs;
      int h;
      int lo;
      int hi;
      qs = int'(query_index);
      h  = last_half[qs];
      lo = last_in_half[qs][0];
      hi = last_in_half[qs][1];
`ifdef LRU_BYPASS_EN
      if (access_valid && access_index == query_index) begin
        h = int'(access_way[1]);
        if (access_way[1]) hi = int'(access_way[0]);
        else               lo = int'(access_way[0]);
      end
`endif
      exp_valid = query_valid;
      if (query_valid) exp_way = 2'(model_victim(h, lo, hi, way_valid));
      if (access_valid) begin
        last_half[access_index] = int'(access_way[1]);
        last_in_half[access_index][access_way[1]] = int'(access_way[0]);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      n_checks++;
      if (victim_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL model victim_valid t=%0t: got %b expected %b", $time, victim_valid, exp_valid);
      end
      n_checks++;
      if (victim_way !== exp_way) begin
        n_fail++;
        $display("FAIL model victim_way t=%0t: got %0d expected %0d", $time, victim_way, exp_way);
      end
    end
  end

  task automatic check_lit(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and land 1 time unit after the edge.
  task automatic cyc(input logic av, input int ai, input int aw,
                     input logic qv, input int qi, input logic [3:0] wv);
    access_valid = av;
    access_index = IDX_W'(ai);
    access_way   = 2'(aw);
    query_valid  = qv;
    query_index  = IDX_W'(qi);
    way_valid    = wv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0, 1'b0, 0, 4'hF);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    checking = 0;
    clk = 0;
    rst = 1;
    access_valid = 0; access_index = '0; access_way = '0;
    query_valid = 0;  query_index = '0;  way_valid = 4'hF;

    repeat (2) @(posedge clk);
    #1;
    checking = 1;
    check_lit("reset victim_valid", {3'b0, victim_valid}, 4'd0);
    check_lit("reset victim_way", {2'b0, victim_way}, 4'd0);
    rst = 0;

    // Fresh set, all valid: tree points at way 3.
    cyc(1'b0, 0, 0, 1'b1, 5, 4'hF);
    check_lit("q set5 valid", {3'b0, victim_valid}, 4'd1);
    check_lit("q set5 way", {2'b0, victim_way}, 4'd3);
    idle();
    check_lit("idle valid drops", {3'b0, victim_valid}, 4'd0);
    check_lit("idle way holds", {2'b0, victim_way}, 4'd3);

    // Access way 3 -> state 101 -> victim 1.
    cyc(1'b1, 2, 3, 1'b0, 0, 4'hF);
    cyc(1'b0, 0, 0, 1'b1, 2, 4'hF);
    check_lit("set2 after way3", {2'b0, victim_way}, 4'd1);

    // Ways 0,1,2,3 in a row -> state 111 -> victim 0.
    for (int w = 0; w < 4; w++) cyc(1'b1, 2, w, 1'b0, 0, 4'hF);
    cyc(1'b0, 0, 0, 1'b1, 2, 4'hF);
    check_lit("set2 after 0123", {2'b0, victim_way}, 4'd0);

    // Invalid ways override the tree.
    cyc(1'b0, 0, 0, 1'b1, 2, 4'b1011);
    check_lit("set2 wv1011", {2'b0, victim_way}, 4'd2);
    cyc(1'b0, 0, 0, 1'b1, 5, 4'b1011);
    check_lit("set5 wv1011", {2'b0, victim_way}, 4'd2);
    cyc(1'b0, 0, 0, 1'b1, 5, 4'b0000);
    check_lit("set5 wv0000", {2'b0, victim_way}, 4'd0);
    cyc(1'b0, 0, 0, 1'b1, 2, 4'b0111);
    check_lit("set2 wv0111", {2'b0, victim_way}, 4'd3);

    // Back-to-back queries, one result per cycle.
    cyc(1'b0, 0, 0, 1'b1, 2, 4'hF);
    check_lit("b2b first", {2'b0, victim_way}, 4'd0);
    cyc(1'b0, 0, 0, 1'b1, 5, 4'hF);
    check_lit("b2b second", {2'b0, victim_way}, 4'd3);
    check_lit("b2b valid", {3'b0, victim_valid}, 4'd1);

    // Access and query to different sets are independent.
    cyc(1'b1, 6, 0, 1'b1, 2, 4'hF);
    check_lit("indep set2", {2'b0, victim_way}, 4'd0);
    cyc(1'b0, 0, 0, 1'b1, 6, 4'hF);
    check_lit("set6 after way0", {2'b0, victim_way}, 4'd3);
    cyc(1'b1, 6, 2, 1'b0, 0, 4'hF);
    cyc(1'b0, 0, 0, 1'b1, 6, 4'hF);
    check_lit("set6 after way2", {2'b0, victim_way}, 4'd1);

    // Same-set access and query in one cycle.
    cyc(1'b1, 4, 3, 1'b1, 4, 4'hF);
`ifdef LRU_BYPASS_EN
    check_lit("same-set bypass", {2'b0, victim_way}, 4'd1);
`else
    check_lit("same-set no bypass", {2'b0, victim_way}, 4'd3);
`endif
    idle();
    cyc(1'b0, 0, 0, 1'b1, 4, 4'hF);
    check_lit("set4 committed", {2'b0, victim_way}, 4'd1);

    // Mid-cycle async reset with a pulse on the output and a query in flight.
    cyc(1'b0, 0, 0, 1'b1, 2, 4'hF);
    check_lit("pre-reset pulse", {3'b0, victim_valid}, 4'd1);
    check_lit("pre-reset way", {2'b0, victim_way}, 4'd0);
    access_valid = 1; access_index = IDX_W'(2); access_way = 2'd1;
    query_valid  = 1; query_index  = IDX_W'(2);
    #2;
    rst = 1;
    #1;
    check_lit("async rst valid", {3'b0, victim_valid}, 4'd0);
    check_lit("async rst way", {2'b0, victim_way}, 4'd0);
    @(posedge clk);
    #1;
    check_lit("rst held valid", {3'b0, victim_valid}, 4'd0);
    rst = 0;
    idle();
    check_lit("post-rst idle", {3'b0, victim_valid}, 4'd0);
    cyc(1'b0, 0, 0, 1'b1, 2, 4'hF);
    check_lit("post-rst set2", {2'b0, victim_way}, 4'd3);
    cyc(1'b0, 0, 0, 1'b1, 6, 4'hF);
    check_lit("post-rst set6", {2'b0, victim_way}, 4'd3);
    idle();
    idle();

    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
